// File: rtl/value_display.sv
// Purpose: turns a binary reading into DIGITS decimal glyphs plus a suffix glyph over a pixel stream; VALUE_DISPLAY_BLINK_EN adds alarm blinking.
// Latency: VALUE_W+2 cycles from strobe to staged result, shown at the next frame_start; on_display is combinational in x/y.
// Backpressure: none; strobes arriving while busy park in a one-deep pending slot where the newest reading wins.

module font16x32 (
    input  logic [3:0] code,
    input  logic [3:0] col,
    input  logic [4:0] row,
    output logic       pixel
);
    function automatic logic in_box(input logic [4:0] r, input logic [3:0] c,
                                    input int r0, input int r1, input int c0, input int c1);
        return (int'(r) >= r0) && (int'(r) <= r1) && (int'(c) >= c0) && (int'(c) <= c1);
    endfunction

    logic [6:0] seg;
    logic [6:0] seg_hit;

    // Digits are seven-segment bars (bit order gfedcba); 4'ha is '%', every other code is blank.
    always_comb begin
        seg = 7'h00;
        case (code)
            4'h0: seg = 7'h3f;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5b;
            4'h3: seg = 7'h4f;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6d;
            4'h6: seg = 7'h7d;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7f;
            4'h9: seg = 7'h6f;
            default: seg = 7'h00;
        endcase
        seg_hit[0] = in_box(row, col,  1,  3,  3, 12);
        seg_hit[1] = in_box(row, col,  3, 15, 12, 14);
        seg_hit[2] = in_box(row, col, 16, 28, 12, 14);
        seg_hit[3] = in_box(row, col, 28, 30,  3, 12);
        seg_hit[4] = in_box(row, col, 16, 28,  1,  3);
        seg_hit[5] = in_box(row, col,  3, 15,  1,  3);
        seg_hit[6] = in_box(row, col, 14, 17,  3, 12);
        pixel = |(seg & seg_hit);
        if (code == 4'ha) begin
            pixel = in_box(row, col, 2, 7, 1, 5) || in_box(row, col, 24, 29, 10, 14) ||
                    (col == 4'(4'd15 - row[4:1]));
        end
    end
endmodule

module value_display #(
    parameter int         X1           = 0,
    parameter int         Y1           = 0,
    parameter int         DIGITS       = 2,
    parameter int         VALUE_W      = 8,
    parameter logic [3:0] SUFFIX_CODE  = 4'ha,
    parameter int         ALARM_LEVEL  = 80,
    parameter int         BLINK_FRAMES = 30
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [VALUE_W-1:0] value,
    input  logic               value_valid,
    input  logic               frame_start,
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    output logic               busy,
    output logic               on_display
);
    localparam int BCD_W   = 4 * DIGITS;
    localparam int MAX_VAL = (DIGITS == 1) ? 9 : (DIGITS == 2) ? 99 : (DIGITS == 3) ? 999 : 9999;

    typedef enum logic [1:0] {IDLE, CONVERT, STORE} state_t;

    state_t             state_q, state_d;
    logic [VALUE_W-1:0] bin_q, bin_d;
    logic [VALUE_W-1:0] pend_val_q, pend_val_d;
    logic               pend_vld_q, pend_vld_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d, bcd_adj;
    logic [BCD_W-1:0]   staged_q, staged_d;
    logic               staged_vld_q, staged_vld_d;
    logic [BCD_W-1:0]   disp_q, disp_d;
    logic [3:0]         cnt_q, cnt_d;

    // Clamping keeps the result inside DIGITS nibbles, so no BCD carry is ever lost.
    function automatic logic [VALUE_W-1:0] clamp(input logic [VALUE_W-1:0] v);
        if (32'(v) > MAX_VAL) return VALUE_W'(MAX_VAL);
        return v;
    endfunction

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_d      = state_q;
        bin_d        = bin_q;
        bcd_d        = bcd_q;
        cnt_d        = cnt_q;
        pend_val_d   = pend_val_q;
        pend_vld_d   = pend_vld_q;
        staged_d     = staged_q;
        staged_vld_d = staged_vld_q;
        disp_d       = disp_q;

        // Commit uses the registered stage, so a same-cycle STORE waits for the following frame.
        if (frame_start && staged_vld_q) begin
            disp_d       = staged_q;
            staged_vld_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (value_valid || pend_vld_q) begin
                    bin_d      = clamp(value_valid ? value : pend_val_q);
                    bcd_d      = '0;
                    cnt_d      = '0;
                    pend_vld_d = 1'b0;
                    state_d    = CONVERT;
                end
            end
            CONVERT: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                cnt_d          = cnt_q + 4'd1;
                if (cnt_q == 4'(VALUE_W - 1)) state_d = STORE;
            end
            STORE: begin
                staged_d     = bcd_q;
                staged_vld_d = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (value_valid && state_q != IDLE) begin
            pend_val_d = value;
            pend_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bin_q        <= '0;
            bcd_q        <= '0;
            cnt_q        <= '0;
            pend_val_q   <= '0;
            pend_vld_q   <= 1'b0;
            staged_q     <= '0;
            staged_vld_q <= 1'b0;
            disp_q       <= '0;
        end else begin
            state_q      <= state_d;
            bin_q        <= bin_d;
            bcd_q        <= bcd_d;
            cnt_q        <= cnt_d;
            pend_val_q   <= pend_val_d;
            pend_vld_q   <= pend_vld_d;
            staged_q     <= staged_d;
            staged_vld_q <= staged_vld_d;
            disp_q       <= disp_d;
        end
    end

    assign busy = (state_q != IDLE);

    logic       digits_on;
`ifdef VALUE_DISPLAY_BLINK_EN
    localparam int BCNT_W = $clog2(2 * BLINK_FRAMES + 1);

    logic [BCNT_W-1:0] blink_q, blink_d;
    int unsigned       disp_bin;
    logic              alarm;

    // Counter sits at zero outside the alarm, so each alarm episode starts in the shown phase.
    always_comb begin
        disp_bin = 0;
        for (int i = DIGITS - 1; i >= 0; i--) disp_bin = disp_bin * 32'd10 + 32'(disp_q[4*i +: 4]);
        alarm   = (disp_bin >= ALARM_LEVEL);
        blink_d = blink_q;
        if (!alarm) blink_d = '0;
        else if (frame_start)
            blink_d = (blink_q == BCNT_W'(2 * BLINK_FRAMES - 1)) ? '0 : blink_q + BCNT_W'(1);
        digits_on = !(alarm && blink_q >= BCNT_W'(BLINK_FRAMES));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) blink_q <= '0;
        else        blink_q <= blink_d;
    end
`else
    assign digits_on = 1'b1;
`endif

    // Glyph 0 is the leftmost (most significant) digit; glyph DIGITS is the suffix.
    logic [3:0] code [DIGITS+1];
    logic       lead;

    always_comb begin
        lead = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            code[k] = disp_q[4*(DIGITS-1-k) +: 4];
            if (lead && code[k] == 4'h0 && k != DIGITS - 1) code[k] = 4'hf;
            else lead = 1'b0;
        end
        code[DIGITS] = SUFFIX_CODE;
    end

    logic [DIGITS:0] glyph_px;

    for (genvar k = 0; k <= DIGITS; k++) begin : g_glyph
        logic [10:0] dx, dy;
        logic        px;
        assign dx = {1'b0, x} - 11'(X1 + 16 * k);
        assign dy = {1'b0, y} - 11'(Y1);
        font16x32 u_font (
            .code  (code[k]),
            .col   (dx[3:0]),
            .row   (dy[4:0]),
            .pixel (px)
        );
        assign glyph_px[k] = px && (dx < 11'd16) && (dy < 11'd32) && ((k == DIGITS) || digits_on);
    end

    assign on_display = |glyph_px;
endmodule

// File: tb/tb_value_display.sv
// Directed bench for value_display: scoreboard of expected glyph codes, checked by probing sample pixels.
module tb_value_display;
    localparam int X1 = 40;
    localparam int Y1 = 20;
`ifdef VALUE_DISPLAY_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] value = '0;
    logic       value_valid = 1'b0;
    logic       frame_start = 1'b0;
    logic [9:0] x = '0;
    logic [9:0] y = '0;
    logic       busy;
    logic       on_display;

    int          checks = 0;
    int          failures = 0;
    logic [11:0] exp_q[$];
    logic [11:0] cur_exp;
    int          n;

    value_display #(.X1(X1), .Y1(Y1), .DIGITS(2), .VALUE_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .value       (value),
        .value_valid (value_valid),
        .frame_start (frame_start),
        .x           (x),
        .y           (y),
        .busy        (busy),
        .on_display  (on_display)
    );

    always #5 clk = ~clk;

    // Seven-segment patterns (gfedcba) and one probe point inside each bar, then three '%' probes.
    logic [6:0] seg7 [10] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07, 7'h7f, 7'h6f};
    int         prow [10] = '{2, 9, 22, 29, 22, 9, 15, 5, 25, 10};
    int         pcol [10] = '{8, 13, 13, 8, 2, 2, 5, 5, 10, 10};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] model(input int v);
        int         c;
        logic [3:0] tens;
        c    = (v > 99) ? 99 : v;
        tens = 4'(c / 10);
        return {(tens == 4'h0) ? 4'hf : tens, 4'(c % 10), 4'ha};
    endfunction

    function automatic logic exp_pix(input logic [3:0] code, input int p);
        if (code <= 4'd9 && p < 7) return seg7[code][p];
        if (code == 4'ha && p >= 7) return 1'b1;
        return 1'b0;
    endfunction

    task automatic scan(input logic [11:0] codes, input logic digits_lit, input string tag);
        logic [3:0] c;
        for (int k = 0; k < 3; k++) begin
            c = codes[11-4*k -: 4];
            for (int p = 0; p < 10; p++) begin
                x = 10'(X1 + 16 * k + pcol[p]);
                y = 10'(Y1 + prow[p]);
                #1;
                chk($sformatf("%s g%0d p%0d", tag, k, p), 32'(on_display),
                    32'((k < 2 && !digits_lit) ? 1'b0 : exp_pix(c, p)));
            end
        end
        x = 10'(X1 + 48 + 5);
        y = 10'(Y1 + 9);
        #1;
        chk({tag, " outside"}, 32'(on_display), 32'd0);
    endtask

    task automatic frame_pulse();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic strobe(input int v);
        @(negedge clk);
        value       = 8'(v);
        value_valid = 1'b1;
        @(negedge clk);
        value_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int cnt;
        cnt = 0;
        while (busy !== 1'b0 && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        chk({tag, " idle"}, 32'(cnt < 50), 32'd1);
    endtask

    task automatic pop_scan(input logic lit, input string tag);
        chk({tag, " sb"}, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            cur_exp = exp_q.pop_front();
            scan(cur_exp, lit, tag);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12 rst_n = 1'b1;
        @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        exp_q.push_back(model(0));
        frame_pulse();
        pop_scan(1'b1, "reset");

        strobe(57);
        exp_q.push_back(model(57));
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy === 1'b1) n++;
            @(negedge clk);
        end
        chk("busy cycles", 32'(n), 32'd9);
        frame_pulse();
        pop_scan(1'b1, "v57");

        // 200 is staged but not shown; a frame during 10's STORE must commit 99, not 10.
        strobe(200);
        exp_q.push_back(model(200));
        wait_idle("v200");
        strobe(10);
        exp_q.push_back(model(10));
        repeat (8) @(negedge clk);
        chk("store busy", 32'(busy), 32'd1);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        pop_scan(1'b1, "v200");
        frame_pulse();
        pop_scan(1'b1, "v10");

        strobe(5);
        exp_q.push_back(model(5));
        repeat (9) @(negedge clk);
        chk("latency idle", 32'(busy), 32'd0);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        pop_scan(1'b1, "v5");

        strobe(42);
        @(negedge clk);
        strobe(43);
        exp_q.push_back(model(43));
        repeat (20) @(negedge clk);
        wait_idle("v43");
        frame_pulse();
        pop_scan(1'b1, "v43");

        strobe(85);
        exp_q.push_back(model(85));
        wait_idle("v85");
        frame_pulse();
        pop_scan(1'b1, "v85 f0");
        repeat (29) frame_pulse();
        scan(model(85), 1'b1, "v85 f29");
        frame_pulse();
        scan(model(85), !BLINK, "v85 f30");
        repeat (30) frame_pulse();
        scan(model(85), 1'b1, "v85 f60");

        strobe(33);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #2;
        chk("abort busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        scan(model(0), 1'b1, "abort");
        repeat (15) @(negedge clk);
        chk("abort stays idle", 32'(busy), 32'd0);
        frame_pulse();
        scan(model(0), 1'b1, "abort frame");

        chk("sb drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/value_display.md
VALUE_DISPLAY -- requirements
Module: value_display

Interface
REQ-001 The block SHALL have parameter X1, default 0: left pixel column of the most significant digit.
REQ-002 The block SHALL have parameter Y1, default 0: top pixel row of all glyphs.
REQ-003 The block SHALL have parameter DIGITS, default 2, legal range 1..4: number of decimal digit glyphs.
REQ-004 The block SHALL have parameter VALUE_W, default 8, legal range 4..14: width of the binary input value.
REQ-005 The block SHALL have parameter SUFFIX_CODE, default 4'ha ('%'): font16x32 code drawn after the digits.
REQ-006 The block SHALL have parameter ALARM_LEVEL, default 80: blink threshold, used only under the REQ-027 macro.
REQ-007 The block SHALL have parameter BLINK_FRAMES, default 30: blink half-period in frames, used only under the REQ-027 macro.
REQ-008 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-009 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-010 The block SHALL have port value, input, VALUE_W bits: unsigned binary sensor reading.
REQ-011 The block SHALL have port value_valid, input, 1 bit: single-cycle strobe qualifying value.
REQ-012 The block SHALL have port frame_start, input, 1 bit: single-cycle pulse at the start of vertical blanking.
REQ-013 The block SHALL have ports x and y, input, 10 bits each: current pixel coordinates.
REQ-014 The block SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-015 The block SHALL have port on_display, output, 1 bit: combinational; high when (x,y) hits a lit pixel of any glyph.

Function
REQ-016 The FSM SHALL have three states: IDLE, CONVERT and STORE.
REQ-017 In IDLE, value_valid SHALL latch min(value, 10^DIGITS-1) into the shift register, clear the BCD accumulator and enter CONVERT.
REQ-018 CONVERT SHALL run exactly VALUE_W cycles of double-dabble (add 3 to each BCD nibble >=5, then shift left by 1) and then enter STORE.
REQ-019 STORE SHALL write the BCD result to the staged register, set staged_valid and return to IDLE; latency from the strobe edge to staged_valid SHALL be VALUE_W+2 cycles.
REQ-020 busy SHALL be high in CONVERT and STORE and low in IDLE.
REQ-021 value_valid while busy SHALL store value in a one-deep pending register (newest wins); in IDLE with pending set, conversion SHALL start from the pending value the next cycle and clear pending.
REQ-022 On frame_start with staged_valid set, the display register SHALL load the staged value and clear staged_valid; the display register SHALL change at no other time (no tearing).
REQ-023 If STORE and frame_start occur in the same cycle, frame_start SHALL commit the previously staged contents, and the new result SHALL wait for the next frame_start.
REQ-024 Digit i (0 = ones) SHALL be drawn at columns X1+16*(DIGITS-1-i) to +15 and rows Y1 to Y1+31; the suffix SHALL be at column X1+16*DIGITS; each glyph SHALL be rendered by one font16x32 instance.
REQ-025 Leading zeros above the highest nonzero digit SHALL be drawn as code 4'hf (blank glyph); the ones digit SHALL always be drawn.

Reset
REQ-026 Asserting rst_n low SHALL force: FSM to IDLE, busy=0, pending=0, staged_valid=0, display register=0 ("0" plus suffix shown), blink counter=0; this SHALL abort any conversion in progress.

Configuration
REQ-027 With VALUE_DISPLAY_BLINK_EN defined, while the displayed value >= ALARM_LEVEL, the digit glyphs (not the suffix) SHALL be suppressed for BLINK_FRAMES frames and then shown for BLINK_FRAMES frames, alternating, with a frame counter that counts frame_start and restarts at the shown phase when the alarm condition begins.
REQ-028 With VALUE_DISPLAY_BLINK_EN undefined, the digits SHALL always be drawn, no blink counter SHALL exist, and ALARM_LEVEL and BLINK_FRAMES SHALL have no effect.

Verification (DIGITS=2, VALUE_W=8)
REQ-029 Reset release, no strobes -> busy=0; on_display matches blank tens digit, "0" and "%" at X1+16 and X1+32.
REQ-030 value=57 strobe -> busy high 9 cycles; staged_valid at strobe+10; after the next frame_start the glyphs are "5","7","%".
REQ-031 value=200 -> displays "99%"; value=5 -> tens column has no lit pixels and shows "5%".
REQ-032 Strobe 42, then 43 three cycles later, with no frame_start in between -> display commits 43 on the first frame_start after 43 reaches STORE.
REQ-033 Macro on, ALARM_LEVEL=80, BLINK_FRAMES=30, value=85 -> digits lit for frames 0-29 and dark for frames 30-59, "%" always lit; rst_n pulse mid-conversion -> display shows "0%", busy=0.
